// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed 8-digit 7-segment scan driver with tear-free load, DP control and leading-zero blanking
module seg7_scan_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    output logic [3:0]  digit_data,
    output logic [7:0]  an,
    output logic        dp_n,
    output logic        frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);
    localparam logic [2:0] IMAX = 3'(NUM_DIGITS - 1);
    localparam logic [31:0] VMASK = (NUM_DIGITS == 8) ? 32'hFFFF_FFFF : (32'd1 << (4 * NUM_DIGITS)) - 32'd1;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   disp_val;
    logic [31:0]   pend_val;
    logic          pend_flag;
    logic          new_frame;
    logic          tick;
    logic          wrap;
    logic          blank;

    // slot timing and blanking decode from the current scan position
    always_comb begin
        tick  = enable && cnt == CMAX;
        wrap  = tick && idx == IMAX;
        blank = blank_lz && idx != 3'd0 && ((disp_val & VMASK) >> {idx, 2'b00}) == 32'd0;
    end

    // prescaler, digit index and double-buffered value; commit only at frame wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            disp_val  <= '0;
            pend_val  <= '0;
            pend_flag <= 1'b0;
            new_frame <= 1'b1;
        end else begin
            cnt       <= tick ? '0 : enable ? cnt + 1'b1 : cnt;
            idx       <= wrap ? '0 : tick ? idx + 3'd1 : idx;
            pend_val  <= load ? value : pend_val;
            pend_flag <= wrap ? 1'b0 : (load | pend_flag);
            disp_val  <= (wrap && load) ? value : (wrap && pend_flag) ? pend_val : disp_val;
            new_frame <= enable ? wrap : new_frame;
        end
    end

    // registered display outputs, one cycle behind the scan state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an          <= 8'hFF;
            digit_data  <= 4'h0;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= (enable && !blank) ? ~(8'd1 << idx) : 8'hFF;
            digit_data  <= enable ? disp_val[{idx, 2'b00} +: 4] : digit_data;
            dp_n        <= !(enable && !blank && dp_mask[idx]);
            frame_start <= enable && new_frame;
        end
    end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed self-checking bench for seg7_scan_mux (8- and 4-digit builds)
module tb_seg7_scan_mux;
    logic        clk = 1'b0;
    logic        rst_n, enable, load, blank_lz;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic [3:0]  digit_data, digit_data4;
    logic [7:0]  an, an4;
    logic        dp_n, dp_n4, frame_start, frame_start4;
    int          total = 0;
    int          bad = 0;
    int          pos = -1;

    seg7_scan_mux #(.REFRESH_DIV(4), .NUM_DIGITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .digit_data(digit_data), .an(an),
        .dp_n(dp_n), .frame_start(frame_start)
    );

    seg7_scan_mux #(.REFRESH_DIV(4), .NUM_DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
        .dp_mask(dp_mask), .blank_lz(blank_lz), .digit_data(digit_data4), .an(an4),
        .dp_n(dp_n4), .frame_start(frame_start4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // pos is the scan position shown on the outputs after the coming edge
    task automatic step();
        if (!rst_n) pos = -1;
        else if (enable) pos++;
        @(negedge clk);
    endtask

    function automatic int s8();
        return (pos / 4) % 8;
    endfunction

    function automatic int s4();
        return (pos / 4) % 4;
    endfunction

    function automatic logic [7:0] an_of(input int s);
        return 8'hFF ^ (8'd1 << s);
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] v, input int s);
        return v[4*s +: 4];
    endfunction

    task automatic pulse_load(input logic [31:0] v);
        value = v;
        load = 1'b1;
        step();
        load = 1'b0;
        value = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; load = 1'b0; value = 32'h0; dp_mask = 8'h00; blank_lz = 1'b0;
        repeat (3) step();
        total++; if (an !== 8'hFF) begin bad++; $display("FAIL reset_an got=%h exp=ff", an); end
        total++; if (digit_data !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", digit_data); end
        total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp_n); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        total++; if (an4 !== 8'hFF) begin bad++; $display("FAIL reset_an4 got=%h exp=ff", an4); end
        rst_n = 1'b1;
        step();
        total++; if (an !== 8'hFE) begin bad++; $display("FAIL release_an got=%h exp=fe", an); end
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL release_fs got=%b exp=1", frame_start); end
        total++; if (digit_data !== 4'h0) begin bad++; $display("FAIL release_data got=%h exp=0", digit_data); end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 33; i++) begin
            total++; if (an !== an_of(s8())) begin bad++; $display("FAIL scan_an pos=%0d got=%h exp=%h", pos, an, an_of(s8())); end
            total++; if (frame_start !== (pos % 32 == 0)) begin bad++; $display("FAIL scan_fs pos=%0d got=%b", pos, frame_start); end
            total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL scan_dp pos=%0d got=%b exp=1", pos, dp_n); end
            total++; if (an4 !== an_of(s4())) begin bad++; $display("FAIL scan_an4 pos=%0d got=%h exp=%h", pos, an4, an_of(s4())); end
            total++; if (frame_start4 !== (pos % 16 == 0)) begin bad++; $display("FAIL scan_fs4 pos=%0d got=%b", pos, frame_start4); end
            step();
        end
    endtask

    task automatic test_tear_free();
        while (pos % 32 != 13) step();
        pulse_load(32'h1234ABCD);
        while (pos % 32 != 0) begin
            total++; if (digit_data !== 4'h0) begin bad++; $display("FAIL tear_hold pos=%0d got=%h exp=0", pos, digit_data); end
            step();
        end
        for (int i = 0; i < 32; i++) begin
            total++; if (digit_data !== nib(32'h1234ABCD, s8())) begin bad++; $display("FAIL tear_show pos=%0d got=%h exp=%h", pos, digit_data, nib(32'h1234ABCD, s8())); end
            total++; if (an !== an_of(s8())) begin bad++; $display("FAIL tear_an pos=%0d got=%h exp=%h", pos, an, an_of(s8())); end
            step();
        end
    endtask

    task automatic test_load_race();
        while (pos % 32 != 5) step();
        pulse_load(32'h11111111);
        while (pos % 32 != 17) begin
            total++; if (digit_data !== nib(32'h1234ABCD, s8())) begin bad++; $display("FAIL race_old pos=%0d got=%h", pos, digit_data); end
            step();
        end
        pulse_load(32'h22222222);
        while (pos % 32 != 0) begin
            total++; if (digit_data !== nib(32'h1234ABCD, s8())) begin bad++; $display("FAIL race_old2 pos=%0d got=%h", pos, digit_data); end
            step();
        end
        while (pos % 32 != 30) begin
            total++; if (digit_data !== 4'h2) begin bad++; $display("FAIL race_last pos=%0d got=%h exp=2", pos, digit_data); end
            step();
        end
        pulse_load(32'h33333333);
        total++; if (digit_data !== 4'h2) begin bad++; $display("FAIL race_tail pos=%0d got=%h exp=2", pos, digit_data); end
        step();
        for (int i = 0; i < 32; i++) begin
            total++; if (digit_data !== 4'h3) begin bad++; $display("FAIL race_bypass pos=%0d got=%h exp=3", pos, digit_data); end
            step();
        end
    endtask

    task automatic test_blank();
        blank_lz = 1'b1;
        pulse_load(32'h00000050);
        while (pos % 32 != 0) step();
        for (int i = 0; i < 32; i++) begin
            total++; if (an !== (s8() < 2 ? an_of(s8()) : 8'hFF)) begin bad++; $display("FAIL blank50_an pos=%0d got=%h", pos, an); end
            if (s8() < 2) begin
                total++; if (digit_data !== (s8() == 1 ? 4'h5 : 4'h0)) begin bad++; $display("FAIL blank50_data pos=%0d got=%h", pos, digit_data); end
            end
            step();
        end
        pulse_load(32'h0);
        while (pos % 32 != 0) step();
        for (int i = 0; i < 32; i++) begin
            total++; if (an !== (s8() == 0 ? 8'hFE : 8'hFF)) begin bad++; $display("FAIL blank0_an pos=%0d got=%h", pos, an); end
            total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL blank0_dp pos=%0d got=%b exp=1", pos, dp_n); end
            step();
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_dp_enable();
        pulse_load(32'h87654321);
        while (pos % 32 != 0) step();
        dp_mask = 8'h04;
        for (int i = 0; i < 21; i++) begin
            total++; if (dp_n !== (s8() != 2)) begin bad++; $display("FAIL dp pos=%0d an=%h got=%b", pos, an, dp_n); end
            step();
        end
        enable = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            total++; if (an !== 8'hFF) begin bad++; $display("FAIL dis_an got=%h exp=ff", an); end
            total++; if (dp_n !== 1'b1) begin bad++; $display("FAIL dis_dp got=%b exp=1", dp_n); end
            total++; if (digit_data !== 4'h6) begin bad++; $display("FAIL dis_data got=%h exp=6", digit_data); end
            step();
        end
        enable = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            total++; if (an !== an_of(i < 2 ? 5 : 6)) begin bad++; $display("FAIL resume_an i=%0d got=%h exp=%h", i, an, an_of(i < 2 ? 5 : 6)); end
            total++; if (digit_data !== (i < 2 ? 4'h6 : 4'h7)) begin bad++; $display("FAIL resume_data i=%0d got=%h", i, digit_data); end
            step();
        end
    endtask

    task automatic test_num4_reset();
        while (pos % 16 != 2) step();
        pulse_load(32'h00005678);
        step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            total++; if (digit_data4 !== 4'h0) begin bad++; $display("FAIL n4_pending pos=%0d got=%h exp=0", pos, digit_data4); end
            total++; if (an4 !== an_of(s4())) begin bad++; $display("FAIL n4_an pos=%0d got=%h exp=%h", pos, an4, an_of(s4())); end
            total++; if (an4[7:4] !== 4'hF) begin bad++; $display("FAIL n4_upper pos=%0d got=%h exp=f", pos, an4[7:4]); end
            total++; if (frame_start4 !== (pos % 16 == 0)) begin bad++; $display("FAIL n4_fs pos=%0d got=%b", pos, frame_start4); end
            total++; if (digit_data !== 4'h0) begin bad++; $display("FAIL n8_pending pos=%0d got=%h exp=0", pos, digit_data); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_load_race();
        test_blank();
        test_dp_enable();
        test_num4_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Multiplexed scan driver for the board's 8-digit common-anode 7-segment display. Holds a 32-bit hex value and cycles the active-low anodes one digit at a time. For the active digit it presents that digit's nibble to the downstream hex-to-segment decoder's 4-bit data input. Adds frame-synchronous (tear-free) value update, per-digit decimal-point control and optional leading-zero blanking.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays active; legal range >=2; simulation uses 4.
NUM_DIGITS, 8, digits scanned (1..8); anodes at or above NUM_DIGITS are held high.

Ports:
clk  input  1  system clock; the block's only clock
rst_n  input  1  synchronous reset, active-low
enable  input  1  1 = scanning; 0 = all anodes off and scan frozen
load  input  1  one-cycle strobe; captures value into the pending register
value  input  32  hex value; nibble i (bits 4i+3:4i) goes to digit i; digit 0 is rightmost
dp_mask  input  8  bit i = 1 lights the decimal point on digit i; sampled live
blank_lz  input  1  1 = blank leading zero digits
digit_data  output  4  nibble for the active digit; drives the decoder data input
an  output  8  anode enables, active-low, at most one bit low
dp_n  output  1  decimal point for the active digit, active-low
frame_start  output  1  one-cycle pulse when digit 0 becomes active

Behaviour:
- Interface: one clock (clk). Reset (rst_n) is synchronous and active-low.
- Internal state:
  - prescaler cnt, 0..REFRESH_DIV-1
  - digit index idx, 0..NUM_DIGITS-1
  - disp_val[31:0], pend_val[31:0], pend_flag
- Reset (rst_n=0 at a clk edge) clears all internal state. Registered outputs take an=8'hFF, digit_data=4'h0, dp_n=1, frame_start=0. Reset mid-frame discards any pending load.
- Prescaler: while enable=1, cnt increments each cycle. When cnt==REFRESH_DIV-1 (tick), cnt wraps to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0. While enable=0, cnt and idx hold.
- Load: load=1 sets pend_val=value and pend_flag=1. Multiple loads before a commit: last one wins.
- Commit point: a tick that wraps idx to 0. At that edge, if pend_flag=1, disp_val takes the pending value and pend_flag clears. If load=1 in the same cycle as the commit tick, the value on the value port is committed directly (bypass) and pend_flag ends at 0.
- Outputs are registered and reflect idx/disp_val one cycle after those registers update. There is no combinational path from any input to any output.
  - an = all ones except bit idx = 0.
  - digit_data = disp_val nibble idx.
  - dp_n = ~dp_mask[idx].
  - Exception: enable=0 forces an=8'hFF and dp_n=1; digit_data holds.
- Leading-zero blanking: when blank_lz=1, digit i>0 is blank if disp_val nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked. For a blank slot, an=8'hFF and dp_n=1; the slot still lasts REFRESH_DIV cycles so brightness stays uniform.
- frame_start: high for exactly the one output cycle in which digit 0 first becomes active after a wrap. It also pulses after reset release with enable=1.
- After reset release with enable=1, the first output update shows digit 0 (an=8'hFE, digit_data=0).

Test Plan:
- Reset/scan (REFRESH_DIV=4): hold rst_n=0 for 3 cycles -> an=FF, digit_data=0, dp_n=1. Release with enable=1 -> an steps FE,FD,FB,F7,EF,DF,BF,7F, each for 4 cycles, then back to FE; frame_start pulses on each return to FE.
- Tear-free load: pulse load with value=0x1234ABCD while idx=3 -> digit_data unchanged until the next wrap. Then digits 0..7 show D,C,B,A,4,3,2,1.
- Load races: load 0x11111111 then 0x22222222 within one frame -> only 2s are ever displayed. A load of 0x33333333 coincident with the commit tick -> 3s are shown from digit 0 of that same frame.
- Blanking: blank_lz=1 with value 0x00000050 -> only digits 0 (0) and 1 (5) drive an low; slots 2..7 give an=FF. With value 0 -> only digit 0 shows 0.
- DP and enable:
  - dp_mask=8'h04 -> dp_n=0 only while an=FB.
  - Drop enable during digit 5 -> an=FF on the next output cycle.
  - Re-enable -> digit 5 resumes with its remaining count.
- NUM_DIGITS=4: an cycles FE,FD,FB,F7; an[7:4] stays 1 at all times. Reset asserted mid-frame after a load -> pending value is never shown.
